// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the four-digit display scan controller.
// lz_dark() is only referenced when DISPLAY_LZ_BLANK_EN is defined.
package disp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_e;

   localparam int         NUM_DIGITS = 4;
   localparam int         SEL_W      = 2;
   localparam logic [3:0] ANODE_OFF  = 4'b1111;

   // True when digit s and every more significant digit are zero, so the
   // digit is a leading zero. Digit 0 is never dark.
   function automatic logic lz_dark(input logic [15:0] snap, input logic [SEL_W-1:0] s);
      logic dark;
      case (s)
         2'd3:    dark = (snap[15:12] == 4'd0);
         2'd2:    dark = (snap[15:8]  == 8'd0);
         2'd1:    dark = (snap[15:4]  == 12'd0);
         default: dark = 1'b0;
      endcase
      return dark;
   endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Bus between the stopwatch counters (master) and the display scan controller (slave).
interface display_scan_ctrl_if;

   logic                                  enable;
   logic [15:0]                           digits_in;
   logic [disp_pkg::SEL_W-1:0]            sel;
   logic [3:0]                            digit;
   logic [disp_pkg::NUM_DIGITS-1:0]       an_n;
   logic                                  frame_done;

   modport master (
      output enable, digits_in,
      input  sel, digit, an_n, frame_done
   );

   modport slave (
      input  enable, digits_in,
      output sel, digit, an_n, frame_done
   );

endinterface

// File: rtl/display_scan_ctrl_slot_timer.sv
// Loadable down-counter with terminal-count flag; times both BLANK and SHOW phases.
module slot_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign tc = (count == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller: blank/show slots, per-frame digit snapshot.
// Optional leading-zero suppression with `define DISPLAY_LZ_BLANK_EN.
//
// state | meaning
// IDLE  | display dark, sel=0, timer cleared, waiting for enable
// BLANK | all anodes off for BLANK_CYCLES at the start of a slot
// SHOW  | anode of sel low for SCAN_DIV-BLANK_CYCLES cycles
module display_scan_ctrl
   import disp_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic                clk,
   input  logic                rst_n,
   display_scan_ctrl_if.slave  bus
);

   localparam int CNT_W = $clog2(SCAN_DIV);

   localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] SHOW_LD  = CNT_W'(SCAN_DIV - BLANK_CYCLES - 1);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_BLANK = BLANK;
   localparam logic [1:0] S_SHOW  = SHOW;

   logic [1:0]            state, state_nxt;
   logic [SEL_W-1:0]      sel_q, sel_nxt;
   logic [15:0]           snap_q;
   logic                  snap_ld;
   logic [NUM_DIGITS-1:0] an_q, an_nxt;
   logic                  tmr_clr, tmr_load, tmr_tc;
   logic [CNT_W-1:0]      tmr_val;

   slot_timer #(.W(CNT_W)) u_slot_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (tmr_clr),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tc       (tmr_tc)
   );

   always_comb begin
      state_nxt = state;
      sel_nxt   = sel_q;
      snap_ld   = 1'b0;
      tmr_clr   = 1'b0;
      tmr_load  = 1'b0;
      tmr_val   = BLANK_LD;
      case (state)
         S_IDLE: begin
            if (bus.enable) begin
               state_nxt = S_BLANK;
               sel_nxt   = '0;
               snap_ld   = 1'b1;
               tmr_load  = 1'b1;
            end else begin
               tmr_clr   = 1'b1;
            end
         end
         S_BLANK: begin
            if (!bus.enable) begin
               state_nxt = S_IDLE;
               sel_nxt   = '0;
               tmr_clr   = 1'b1;
            end else if (tmr_tc) begin
               state_nxt = S_SHOW;
               tmr_load  = 1'b1;
               tmr_val   = SHOW_LD;
            end
         end
         S_SHOW: begin
            if (!bus.enable) begin
               state_nxt = S_IDLE;
               sel_nxt   = '0;
               tmr_clr   = 1'b1;
            end else if (tmr_tc) begin
               state_nxt = S_BLANK;
               sel_nxt   = sel_q + 1'b1;
               tmr_load  = 1'b1;
               // frame boundary: new digits become visible only from here
               snap_ld   = (sel_q == SEL_LAST);
            end
         end
         default: begin
            state_nxt = S_IDLE;
            sel_nxt   = '0;
            tmr_clr   = 1'b1;
         end
      endcase
   end

   // Anodes are decoded from the next state so they stay registered and
   // only ever go low in cycles where sel is already stable.
   always_comb begin
      an_nxt = ANODE_OFF;
      if (state_nxt == S_SHOW) begin
         an_nxt[sel_nxt] = 1'b0;
`ifdef DISPLAY_LZ_BLANK_EN
         if (lz_dark(snap_q, sel_nxt)) an_nxt = ANODE_OFF;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         sel_q  <= '0;
         snap_q <= '0;
         an_q   <= ANODE_OFF;
      end else begin
         state <= state_nxt;
         sel_q <= sel_nxt;
         an_q  <= an_nxt;
         if (snap_ld) snap_q <= bus.digits_in;
      end
   end

   assign bus.sel        = sel_q;
   assign bus.an_n       = an_q;
   assign bus.digit      = snap_q[{sel_q, 2'b00} +: 4];
   assign bus.frame_done = (state == S_SHOW) && tmr_tc && bus.enable && (sel_q == SEL_LAST);

endmodule
